// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
//
// The operands are split into 4-bit lookahead groups. Each pipeline stage
// evaluates GROUPS_PER_STAGE groups, chaining their carries combinationally,
// and registers the group carry for the next stage. Operand slices that have
// not been consumed yet travel forward with the beat (input skew). Sum slices
// that are already finished travel forward too, so the last stage holds a
// fully aligned result (output deskew).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (A, B, C0, sub)
//   out_valid / out_ready result handshake (S, C_out, ovf, zero)
//   sub=0: S = A + B + C0      sub=1: S = A - B - C0 (C_out=1 means no borrow)
//   ovf  = carry into MSB ^ carry out of MSB;  zero = (S == 0)
//
// Parameters: WIDTH (multiple of 4), GROUPS_PER_STAGE (divides WIDTH/4).

// One 4-bit lookahead group. Every carry is a flat sum of products of the
// group's P/G terms and the carry-in; there is no ripple inside the group.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] p, g;
  logic       c1, c2, c3;

  assign p  = a ^ b;
  assign g  = a & b;
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (&p & ci);
  assign s  = p ^ {c3, c2, c1, ci};
endmodule

module pipelined_cla_addsub #(
  parameter int WIDTH            = 16,
  parameter int GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             ovf,
  output logic             zero
);
  localparam int NGROUPS = WIDTH / 4;
  localparam int STAGES  = NGROUPS / GROUPS_PER_STAGE;
  localparam int SW      = 4 * GROUPS_PER_STAGE;   // bits resolved per stage

  logic [STAGES-1:0] vld_pipe, adv, ld;
  logic              rdy0;

  // Ready ripples back from the output: a stage can take a beat if it is
  // empty or its own beat moves on this cycle.
  always_comb begin : hs
    logic r;
    r   = out_ready;
    adv = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = vld_pipe[k] & r;
      r      = ~vld_pipe[k] | adv[k];
    end
    rdy0 = r;
  end

  // Gated with rst_n so nothing is offered as accepted while reset is held.
  assign in_ready = rst_n & rdy0;

  always_comb begin
    ld    = '0;
    ld[0] = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) ld[k] = adv[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k])       vld_pipe[k] <= 1'b1;
        else if (adv[k]) vld_pipe[k] <= 1'b0;
      end
    end
  end

  assign out_valid = vld_pipe[STAGES-1];
  assign zero      = out_valid & ~|S;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int RIN = WIDTH - k * SW;   // operand bits still unconsumed
    logic [RIN-1:0]      a_in, b_in;
    logic                c_in;
    logic [SW-1:0]       s_grp;
    logic [(k+1)*SW-1:0] s_nxt, s_q;

    // B is inverted (and the carry-in flipped) once at entry, so later
    // stages see a plain add and no longer need the sub flag.
    if (k == 0) begin : g_src
      assign a_in  = A;
      assign b_in  = B ^ {WIDTH{sub}};
      assign c_in  = C0 ^ sub;
      assign s_nxt = s_grp;
    end else begin : g_src
      assign a_in  = stg[k-1].g_mid.a_q;
      assign b_in  = stg[k-1].g_mid.b_q;
      assign c_in  = stg[k-1].g_mid.c_q;
      assign s_nxt = {s_grp, stg[k-1].s_q};
    end

    for (genvar j = 0; j < GROUPS_PER_STAGE; j++) begin : grp
      logic       ci, co;
      logic [3:0] s;
      if (j == 0) begin : g_ci
        assign ci = c_in;
      end else begin : g_ci
        assign ci = grp[j-1].co;
      end
      cla4 u_cla (.a(a_in[4*j +: 4]), .b(b_in[4*j +: 4]), .ci(ci), .s(s), .co(co));
      assign s_grp[4*j +: 4] = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     s_q <= '0;
      else if (ld[k]) s_q <= s_nxt;
    end

    if (k < STAGES - 1) begin : g_mid
      logic [RIN-SW-1:0] a_q, b_q;
      logic              c_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (ld[k]) begin
          a_q <= a_in[RIN-1:SW];
          b_q <= b_in[RIN-1:SW];
          c_q <= grp[GROUPS_PER_STAGE-1].co;
        end
      end
    end else begin : g_last
      logic co_q, ovf_q, c_msb;
      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
      assign c_msb = a_in[RIN-1] ^ b_in[RIN-1] ^ s_grp[SW-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          co_q  <= 1'b0;
          ovf_q <= 1'b0;
        end else if (ld[k]) begin
          co_q  <= grp[GROUPS_PER_STAGE-1].co;
          ovf_q <= grp[GROUPS_PER_STAGE-1].co ^ c_msb;
        end
      end
      assign S     = s_q;
      assign C_out = co_q;
      assign ovf   = ovf_q;
    end
  end
endmodule
